// File: rtl/ts_os_qualifier.sv
// TS1/TS2/idle ordered-set qualifier.
// Counts consecutive matching training sets (keyed on link, lane, N_FTS,
// rate ID and training control) and consecutive idle symbols, raises the
// matching detect flag once the run length reaches its threshold, and
// keeps the fields of the most recently accepted training set.

package ts_os_qualifier_pkg;

    typedef enum logic [1:0] {
        RATE_GEN1 = 2'd0,
        RATE_GEN2 = 2'd1,
        RATE_GEN3 = 2'd2,
        RATE_GEN4 = 2'd3
    } rate_speed_e;

    // Byte k of the ordered set lives in bits [8k+7:8k].
    typedef logic [127:0] pcie_ordered_set_t;

    // K23.7 PAD symbol as it appears in the link/lane number byte.
    localparam logic [7:0] PAD_ = 8'hF7;

endpackage

module ts_os_qualifier
    import ts_os_qualifier_pkg::*;
#(
    parameter int CONSEC_TS   = 8,
    parameter int CONSEC_IDLE = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  rate_speed_e       curr_data_rate_i,
    input  pcie_ordered_set_t ordered_set_i,
    input  logic              ts1_valid_i,
    input  logic              ts2_valid_i,
    input  logic              eieos_valid_i,
    input  logic              idle_valid_i,
    input  logic              clear_i,
    output logic              ts1_det_o,
    output logic              ts2_det_o,
    output logic              idle_det_o,
    output logic              ts1_rx_o,
    output logic              ts2_rx_o,
    output logic [7:0]        link_num_o,
    output logic [7:0]        lane_num_o,
    output logic [7:0]        nfts_o,
    output logic [7:0]        rate_id_o,
    output logic [7:0]        train_ctrl_o,
    output logic              link_pad_o,
    output logic              lane_pad_o
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_TS1_TRACK = 2'd1;
    localparam logic [1:0] ST_TS2_TRACK = 2'd2;
    localparam logic [1:0] ST_IDL_TRACK = 2'd3;

    localparam logic [4:0] TS_THR   = 5'(CONSEC_TS);
    localparam logic [4:0] IDLE_THR = 5'(CONSEC_IDLE);

    logic [1:0]  state_q, state_d;
    logic [4:0]  tsCount_q, tsCount_d;
    logic [4:0]  idleCount_q, idleCount_d;
    logic [39:0] key_q, key_d;
    rate_speed_e prevRate_q;

    logic [39:0] rxKey;
    logic        rateChange;
    logic        flush;
    logic        bothTs;
    logic        acceptTs1;
    logic        acceptTs2;
    logic        ts1Det_d;
    logic        ts2Det_d;
    logic        idleDet_d;
    logic        unusedOsBits;

    // Bytes 1..5 form the training-set key; the remaining bytes and the
    // eieos qualifier never influence the qualifier state.
    assign rxKey        = ordered_set_i[47:8];
    assign unusedOsBits = ^{ordered_set_i[127:48], ordered_set_i[7:0], eieos_valid_i};

    // A rate change behaves exactly like an LTSSM clear for that cycle.
    assign rateChange = (curr_data_rate_i != prevRate_q);
    assign flush      = clear_i | rateChange;
    assign bothTs     = ts1_valid_i & ts2_valid_i;
    assign acceptTs1  = ~flush & ts1_valid_i & ~ts2_valid_i;
    assign acceptTs2  = ~flush & ts2_valid_i & ~ts1_valid_i;

    // Next-state and counter update; flush beats simultaneous TS1/TS2,
    // which beats a single TS, which beats idle.
    always_comb begin
        state_d     = state_q;
        tsCount_d   = tsCount_q;
        idleCount_d = idleCount_q;
        key_d       = key_q;
        if (flush || bothTs) begin
            state_d     = ST_IDLE;
            tsCount_d   = 5'd0;
            idleCount_d = 5'd0;
        end else if (ts1_valid_i) begin
            idleCount_d = 5'd0;
            if (state_q == ST_TS1_TRACK && rxKey == key_q) begin
                tsCount_d = (tsCount_q >= TS_THR) ? TS_THR : tsCount_q + 5'd1;
            end else begin
                state_d   = ST_TS1_TRACK;
                key_d     = rxKey;
                tsCount_d = 5'd1;
            end
        end else if (ts2_valid_i) begin
            idleCount_d = 5'd0;
            if (state_q == ST_TS2_TRACK && rxKey == key_q) begin
                tsCount_d = (tsCount_q >= TS_THR) ? TS_THR : tsCount_q + 5'd1;
            end else begin
                state_d   = ST_TS2_TRACK;
                key_d     = rxKey;
                tsCount_d = 5'd1;
            end
        end else if (idle_valid_i) begin
            state_d     = ST_IDL_TRACK;
            tsCount_d   = 5'd0;
            idleCount_d = (idleCount_q >= IDLE_THR) ? IDLE_THR : idleCount_q + 5'd1;
        end
    end

    // Detect flags follow the next state so they appear the cycle after
    // the qualifying event.
    always_comb begin
        ts1Det_d  = (state_d == ST_TS1_TRACK) && (tsCount_d == TS_THR);
        ts2Det_d  = (state_d == ST_TS2_TRACK) && (tsCount_d == TS_THR);
        idleDet_d = (idleCount_d == IDLE_THR);
    end

    // Tracking state, counters, stored key and previous link rate.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            tsCount_q   <= 5'd0;
            idleCount_q <= 5'd0;
            key_q       <= 40'd0;
            prevRate_q  <= curr_data_rate_i;
        end else begin
            state_q     <= state_d;
            tsCount_q   <= tsCount_d;
            idleCount_q <= idleCount_d;
            key_q       <= key_d;
            prevRate_q  <= curr_data_rate_i;
        end
    end

    // Registered outputs: detect flags, receive pulses and captured fields,
    // which survive clears and only change on an accepted training set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts1_det_o    <= 1'b0;
            ts2_det_o    <= 1'b0;
            idle_det_o   <= 1'b0;
            ts1_rx_o     <= 1'b0;
            ts2_rx_o     <= 1'b0;
            link_num_o   <= 8'd0;
            lane_num_o   <= 8'd0;
            nfts_o       <= 8'd0;
            rate_id_o    <= 8'd0;
            train_ctrl_o <= 8'd0;
            link_pad_o   <= 1'b0;
            lane_pad_o   <= 1'b0;
        end else begin
            ts1_det_o  <= ts1Det_d;
            ts2_det_o  <= ts2Det_d;
            idle_det_o <= idleDet_d;
            ts1_rx_o   <= acceptTs1;
            ts2_rx_o   <= acceptTs2;
            if (acceptTs1 || acceptTs2) begin
                link_num_o   <= ordered_set_i[15:8];
                lane_num_o   <= ordered_set_i[23:16];
                nfts_o       <= ordered_set_i[31:24];
                rate_id_o    <= ordered_set_i[39:32];
                train_ctrl_o <= ordered_set_i[47:40];
                link_pad_o   <= (ordered_set_i[15:8] == PAD_);
                lane_pad_o   <= (ordered_set_i[23:16] == PAD_);
            end
        end
    end

endmodule

// File: tb/tb_ts_os_qualifier.sv
// Testbench for ts_os_qualifier: directed scenarios followed by random
// ordered-set traffic, all scored against a run-length reference model.

module tb_ts_os_qualifier;
    import ts_os_qualifier_pkg::*;

    localparam int CONSEC_TS   = 8;
    localparam int CONSEC_IDLE = 8;

    localparam int KIND_NONE = 0;
    localparam int KIND_TS1  = 1;
    localparam int KIND_TS2  = 2;
    localparam int KIND_IDLE = 3;

    typedef struct packed {
        logic       ts1Det;
        logic       ts2Det;
        logic       idleDet;
        logic       ts1Rx;
        logic       ts2Rx;
        logic [7:0] link;
        logic [7:0] lane;
        logic [7:0] nfts;
        logic [7:0] rateId;
        logic [7:0] trainCtrl;
        logic       linkPad;
        logic       lanePad;
    } outVec_t;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    rate_speed_e       curr_data_rate_i = RATE_GEN1;
    pcie_ordered_set_t ordered_set_i = '0;
    logic              ts1_valid_i = 1'b0;
    logic              ts2_valid_i = 1'b0;
    logic              eieos_valid_i = 1'b0;
    logic              idle_valid_i = 1'b0;
    logic              clear_i = 1'b0;
    logic              ts1_det_o, ts2_det_o, idle_det_o;
    logic              ts1_rx_o, ts2_rx_o;
    logic [7:0]        link_num_o, lane_num_o, nfts_o, rate_id_o, train_ctrl_o;
    logic              link_pad_o, lane_pad_o;

    outVec_t     actualOut;
    outVec_t     expQ[$];
    int          checks = 0;
    int          errors = 0;

    rate_speed_e curRate = RATE_GEN1;
    int          runKind = KIND_NONE;
    int          runLen = 0;
    int          idleLen = 0;
    logic [39:0] modelKey = '0;
    rate_speed_e modelPrevRate = RATE_GEN1;
    outVec_t     modelOut = '0;

    ts_os_qualifier #(
        .CONSEC_TS   (CONSEC_TS),
        .CONSEC_IDLE (CONSEC_IDLE)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .curr_data_rate_i (curr_data_rate_i),
        .ordered_set_i    (ordered_set_i),
        .ts1_valid_i      (ts1_valid_i),
        .ts2_valid_i      (ts2_valid_i),
        .eieos_valid_i    (eieos_valid_i),
        .idle_valid_i     (idle_valid_i),
        .clear_i          (clear_i),
        .ts1_det_o        (ts1_det_o),
        .ts2_det_o        (ts2_det_o),
        .idle_det_o       (idle_det_o),
        .ts1_rx_o         (ts1_rx_o),
        .ts2_rx_o         (ts2_rx_o),
        .link_num_o       (link_num_o),
        .lane_num_o       (lane_num_o),
        .nfts_o           (nfts_o),
        .rate_id_o        (rate_id_o),
        .train_ctrl_o     (train_ctrl_o),
        .link_pad_o       (link_pad_o),
        .lane_pad_o       (lane_pad_o)
    );

    // Free-running 10 ns clock.
    always #5 clk_i = ~clk_i;

    assign actualOut = {ts1_det_o, ts2_det_o, idle_det_o, ts1_rx_o, ts2_rx_o,
                        link_num_o, lane_num_o, nfts_o, rate_id_o, train_ctrl_o,
                        link_pad_o, lane_pad_o};

    // Build an ordered set with the given key bytes; byte 0 is COM and the
    // unkeyed bytes are random so they are shown to be ignored.
    function automatic pcie_ordered_set_t mkOs(input logic [7:0] link, input logic [7:0] lane,
                                               input logic [7:0] nfts, input logic [7:0] rateId,
                                               input logic [7:0] ctrl);
        logic [95:0] filler;
        filler = {$urandom, $urandom, $urandom};
        return {filler[79:0], ctrl, rateId, nfts, lane, link, 8'hBC};
    endfunction

    // Reference model: one call per clock; tracks the length of the current
    // run of identical training sets or idles and the last accepted fields.
    task automatic modelStep(input bit rst, input bit clr, input bit t1, input bit t2,
                             input bit id, input pcie_ordered_set_t os);
        int kind;
        if (rst) begin
            runKind       = KIND_NONE;
            runLen        = 0;
            idleLen       = 0;
            modelKey      = '0;
            modelOut      = '0;
            modelPrevRate = curRate;
            return;
        end
        modelOut.ts1Rx = 1'b0;
        modelOut.ts2Rx = 1'b0;
        if (clr || curRate != modelPrevRate || (t1 && t2)) begin
            runKind = KIND_NONE;
            runLen  = 0;
            idleLen = 0;
        end else if (t1 || t2) begin
            kind = t1 ? KIND_TS1 : KIND_TS2;
            if (runKind == kind && os[47:8] == modelKey) begin
                runLen = runLen + 1;
            end else begin
                runKind  = kind;
                runLen   = 1;
                modelKey = os[47:8];
            end
            idleLen            = 0;
            modelOut.ts1Rx     = t1;
            modelOut.ts2Rx     = t2;
            modelOut.link      = os[15:8];
            modelOut.lane      = os[23:16];
            modelOut.nfts      = os[31:24];
            modelOut.rateId    = os[39:32];
            modelOut.trainCtrl = os[47:40];
            modelOut.linkPad   = (os[15:8] == PAD_);
            modelOut.lanePad   = (os[23:16] == PAD_);
        end else if (id) begin
            runKind = KIND_IDLE;
            runLen  = 0;
            idleLen = idleLen + 1;
        end
        modelPrevRate    = curRate;
        modelOut.ts1Det  = (runKind == KIND_TS1) && (runLen >= CONSEC_TS);
        modelOut.ts2Det  = (runKind == KIND_TS2) && (runLen >= CONSEC_TS);
        modelOut.idleDet = (idleLen >= CONSEC_IDLE);
    endtask

    // Drive one cycle of inputs on the falling edge and queue the expected
    // outputs for the following rising edge.
    task automatic applyStimulus(input bit rst, input bit clr, input bit t1, input bit t2,
                                 input bit ei, input bit id, input pcie_ordered_set_t os);
        @(negedge clk_i);
        rst_i            = rst;
        clear_i          = clr;
        ts1_valid_i      = t1;
        ts2_valid_i      = t2;
        eieos_valid_i    = ei;
        idle_valid_i     = id;
        ordered_set_i    = os;
        curr_data_rate_i = curRate;
        modelStep(rst, clr, t1, t2, id, os);
        expQ.push_back(modelOut);
    endtask

    // Directed check of one output just after the edge that consumed the
    // last stimulus.
    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic sampleAndCheck(input string name, input int which, input logic [7:0] req);
        @(posedge clk_i);
        #1;
        case (which)
            0: checkOutput(name, {7'd0, ts1_det_o}, req);
            1: checkOutput(name, {7'd0, ts2_det_o}, req);
            2: checkOutput(name, {7'd0, idle_det_o}, req);
            3: checkOutput(name, {7'd0, ts1_rx_o}, req);
            4: checkOutput(name, link_num_o, req);
            5: checkOutput(name, {7'd0, link_pad_o}, req);
            6: checkOutput(name, {5'd0, ts1_det_o, ts2_det_o, idle_det_o}, req);
            default: checkOutput(name, {7'd0, lane_pad_o}, req);
        endcase
    endtask

    // Scoreboard monitor: every clock the registered outputs are compared
    // with the oldest queued expectation.
    initial begin
        outVec_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checks++;
                if (actualOut !== e) begin
                    errors++;
                    $display("[TB] FAIL scoreboard at %0t actual=%h required=%h", $time, actualOut, e);
                end
            end
        end
    end

    // Main stimulus: reset, directed scenarios, then random traffic.
    initial begin
        pcie_ordered_set_t osA, osB, osPad;
        int r;
        int sel;

        osA   = mkOs(8'h01, 8'h00, 8'h20, 8'h02, 8'h00);
        osB   = mkOs(8'h01, 8'h02, 8'h20, 8'h02, 8'h00);
        osPad = mkOs(PAD_, 8'h00, 8'h20, 8'h02, 8'h00);

        applyStimulus(1, 0, 0, 0, 0, 0, '0);
        applyStimulus(1, 0, 0, 0, 0, 0, '0);
        sampleAndCheck("reset_dets", 6, 8'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, '0);
        sampleAndCheck("reset_link", 4, 8'd0);

        // Eight matching TS1.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 0, mkOs(8'h01, 8'h00, 8'h20, 8'h02, 8'h00));
            if (i == 6) sampleAndCheck("ts1_det_after7", 0, 8'd0);
            if (i == 7) sampleAndCheck("ts1_det_after8", 0, 8'd1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, osA);
        sampleAndCheck("link_num_01", 4, 8'h01);

        // Mismatch restarts the run.
        applyStimulus(0, 1, 0, 0, 0, 0, osA);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, 0, 0, 0, osA);
        applyStimulus(0, 0, 1, 0, 0, 0, osB);
        sampleAndCheck("ts1_det_mismatch", 0, 8'd0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 0, osB);
            if (i == 5) sampleAndCheck("ts1_det_after_mm6", 0, 8'd0);
            if (i == 6) sampleAndCheck("ts1_det_after_mm7", 0, 8'd1);
        end

        // EIEOS between the 4th and 5th TS1 is transparent.
        applyStimulus(0, 1, 0, 0, 0, 0, osA);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0, 0, osA);
        applyStimulus(0, 0, 0, 0, 1, 0, osA);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 0, osA);
            if (i == 2) sampleAndCheck("ts1_det_eieos7", 0, 8'd0);
            if (i == 3) sampleAndCheck("ts1_det_eieos8", 0, 8'd1);
        end

        // Clear on the 6th TS2 restarts the count.
        applyStimulus(0, 1, 0, 0, 0, 0, osA);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 0, 0, osA);
        applyStimulus(0, 1, 0, 1, 0, 0, osA);
        sampleAndCheck("ts2_det_clear", 1, 8'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 0, osA);
            if (i == 6) sampleAndCheck("ts2_det_after7", 1, 8'd0);
            if (i == 7) sampleAndCheck("ts2_det_after8", 1, 8'd1);
        end

        // Idle run, broken by a TS1, then a gen1-to-gen2 rate change.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, osA);
            if (i == 6) sampleAndCheck("idle_det_after7", 2, 8'd0);
            if (i == 7) sampleAndCheck("idle_det_after8", 2, 8'd1);
        end
        applyStimulus(0, 0, 1, 0, 0, 0, osA);
        sampleAndCheck("idle_det_after_ts1", 2, 8'd0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, 0, 0, 0, osA);
        sampleAndCheck("ts1_det_before_rate", 0, 8'd1);
        curRate = RATE_GEN2;
        applyStimulus(0, 0, 1, 0, 0, 0, osA);
        sampleAndCheck("dets_after_rate", 6, 8'd0);

        // PAD link number.
        applyStimulus(0, 0, 1, 0, 0, 0, osPad);
        sampleAndCheck("link_pad", 5, 8'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, osA);
        sampleAndCheck("ts1_rx_single", 3, 8'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, osA);
        sampleAndCheck("lane_pad", 7, 8'd0);

        // Random traffic over a small key pool so runs reach threshold.
        for (int n = 0; n < 1500; n++) begin
            r   = $urandom_range(0, 99);
            sel = $urandom_range(0, 99);
            if (sel < 85)      osA = mkOs(8'h01, 8'h00, 8'h20, 8'h02, 8'h00);
            else if (sel < 95) osA = mkOs(8'h01, 8'h02, 8'h20, 8'h02, 8'h00);
            else               osA = mkOs(PAD_, PAD_, 8'h18, 8'h06, 8'h01);
            if (r < 45)      applyStimulus(0, 0, 1, 0, 0, 0, osA);
            else if (r < 65) applyStimulus(0, 0, 0, 1, 0, 0, osA);
            else if (r < 80) applyStimulus(0, 0, 0, 0, 0, 1, osA);
            else if (r < 88) applyStimulus(0, 0, 0, 0, 1, 0, osA);
            else if (r < 90) applyStimulus(0, 0, 1, 1, 0, 0, osA);
            else if (r < 92) applyStimulus(0, 1, $urandom_range(0, 1) == 1, 0, 0, 0, osA);
            else if (r < 93) begin
                curRate = rate_speed_e'(2'($urandom_range(0, 3)));
                applyStimulus(0, 0, 1, 0, 0, 0, osA);
            end else if (r < 94) applyStimulus(1, 0, 0, 0, 0, 0, osA);
            else             applyStimulus(0, 0, 0, 0, 0, 0, osA);
        end

        applyStimulus(0, 0, 0, 0, 0, 0, '0);
        @(posedge clk_i);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ts_os_qualifier.md
TS_OS_QUALIFIER -- requirements
Module: ts_os_qualifier

Interface
REQ-001 SHALL have parameter CONSEC_TS, default 8, meaning consecutive matching TS1/TS2 sets required for detection (legal 1..16).
REQ-002 SHALL have parameter CONSEC_IDLE, default 8, meaning consecutive idle_valid_i pulses required for idle detection (legal 1..16).
REQ-003 SHALL have port clk_i  input  1  clock; the block has one clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port curr_data_rate_i  input  rate_speed_e  current link rate.
REQ-006 SHALL have port ordered_set_i  input  pcie_ordered_set_t  decoded ordered set; byte k is bits [8k+7:8k].
REQ-007 SHALL have ports ts1_valid_i, ts2_valid_i, eieos_valid_i, idle_valid_i  input  1 each  single-cycle qualifiers aligned with ordered_set_i.
REQ-008 SHALL have port clear_i  input  1  LTSSM state-change clear.
REQ-009 SHALL have ports ts1_det_o, ts2_det_o, idle_det_o  output  1 each  consecutive-count thresholds reached.
REQ-010 SHALL have ports ts1_rx_o, ts2_rx_o  output  1 each  one-cycle pulse per TS received.
REQ-011 SHALL have ports link_num_o, lane_num_o, nfts_o, rate_id_o, train_ctrl_o  output  8 each  fields of the last accepted TS.
REQ-012 SHALL have ports link_pad_o, lane_pad_o  output  1 each  captured link/lane number equals PAD_.

Function
REQ-013 SHALL use states ST_IDLE, ST_TS1_TRACK, ST_TS2_TRACK, ST_IDL_TRACK; a 5-bit count saturates at its threshold.
REQ-014 SHALL define the TS key as bytes 1..5 of ordered_set_i (link, lane, N_FTS, rate ID, training control), identical for gen1/2 and gen3.
REQ-015 SHALL, on ts1_valid_i in ST_TS1_TRACK with key equal to stored key, increment count; on key mismatch, reload key and set count=1.
REQ-016 SHALL, on ts1_valid_i in any other state, go to ST_TS1_TRACK, load key, set count=1 and clear idle count; ts2_valid_i is symmetric with ST_TS2_TRACK.
REQ-017 SHALL, on idle_valid_i, go to or stay in ST_IDL_TRACK and increment idle count; any TS pulse clears the idle count.
REQ-018 SHALL treat eieos_valid_i as transparent: no state, count or key change.
REQ-019 SHALL, when ts1_valid_i and ts2_valid_i are both high, go to ST_IDLE, zero all counts and leave captured fields unchanged.
REQ-020 SHALL give clear_i priority over all valid inputs: ST_IDLE, counts=0, det outputs low next cycle; captured fields are retained.
REQ-021 SHALL, when curr_data_rate_i differs from its registered previous value, act as clear_i for that cycle and ignore valids in that cycle.
REQ-022 SHALL assert ts1_det_o in cycle N+1, where N is the cycle of the CONSEC_TS-th consecutive matching TS1; it holds until a mismatch, TS2, clear or rate change.
REQ-023 SHALL handle ts2_det_o and idle_det_o per REQ-022 with their own events and thresholds.
REQ-024 SHALL register all outputs; ts1_rx_o/ts2_rx_o pulse in cycle N+1 for every accepted TS, including mismatches.
REQ-025 SHALL update captured fields and pad flags in cycle N+1 of every accepted TS; PAD_ comparison is on raw byte value.
REQ-026 SHALL hold count at threshold on further matches, without wrap-around.

Reset
REQ-027 SHALL on rst_i set state ST_IDLE, all counts 0, all outputs 0 and the stored key 0; rst_i mid-sequence discards partial counts.

Verification
REQ-028 SHALL test 8 TS1 with link=0x01, lane=0x00 on consecutive valids -> ts1_det_o rises one cycle after the 8th, link_num_o=0x01.
REQ-029 SHALL test 7 matching TS1, then 1 with lane=0x02, then 7 more -> no ts1_det_o until the 8th after the mismatch.
REQ-030 SHALL test 8 TS1 with an eieos_valid_i between the 4th and 5th -> ts1_det_o still asserted after the 8th TS1.
REQ-031 SHALL test 8 TS2 with clear_i on the 6th valid -> count restarts and ts2_det_o asserts only after 8 further TS2.
REQ-032 SHALL test 8 idle_valid_i pulses, then a TS1, then a gen1-to-gen2 rate change -> idle_det_o high, then low; all det outputs low after the rate change.
REQ-033 SHALL test TS1 with link byte PAD_ -> link_pad_o=1 and ts1_rx_o pulses once.
